// File: rtl/bottling_pkg.sv
// Shared types and default widths for the bottling controller and display stage.
package bottling_pkg;

   localparam int unsigned PILL_W_DEF   = 6;
   localparam int unsigned BOTTLE_W_DEF = 10;
   localparam int unsigned DROP_W       = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      SWAP   = 2'd3
   } state_t;

endpackage

// File: rtl/bottling_controller_if.sv
// Command/status bundle of the bottling controller.
// drop_count exists only when BOTTLING_DROP_COUNT_EN is defined.
interface bottling_controller_if
   import bottling_pkg::*;
#(
   parameter int unsigned PILL_W   = PILL_W_DEF,
   parameter int unsigned BOTTLE_W = BOTTLE_W_DEF
);

   logic                pill_pulse;
   logic                start;
   logic                pause;
   logic                stop;
   logic                clear;
   logic                bottle_ready;
   logic [PILL_W-1:0]   target;
   logic [PILL_W-1:0]   pill_count;
   logic [BOTTLE_W-1:0] bottle_count;
   logic                bottle_done;
   logic                swap_req;
   logic                busy;
   logic                start_err;
`ifdef BOTTLING_DROP_COUNT_EN
   logic [DROP_W-1:0]   drop_count;

   modport master (
      output pill_pulse, start, pause, stop, clear, bottle_ready, target,
      input  pill_count, bottle_count, bottle_done, swap_req, busy, start_err, drop_count
   );

   modport slave (
      input  pill_pulse, start, pause, stop, clear, bottle_ready, target,
      output pill_count, bottle_count, bottle_done, swap_req, busy, start_err, drop_count
   );
`else
   modport master (
      output pill_pulse, start, pause, stop, clear, bottle_ready, target,
      input  pill_count, bottle_count, bottle_done, swap_req, busy, start_err
   );

   modport slave (
      input  pill_pulse, start, pause, stop, clear, bottle_ready, target,
      output pill_count, bottle_count, bottle_done, swap_req, busy, start_err
   );
`endif

endinterface

// File: rtl/bottling_sat_counter.sv
// Saturating up-counter with synchronous clear.
module bottling_sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/bottling_controller.sv
// Per-bottle pill counter and bottle-change sequencer.
// Optional drop counter enabled by BOTTLING_DROP_COUNT_EN.
module bottling_controller
   import bottling_pkg::*;
#(
   parameter int unsigned PILL_W   = PILL_W_DEF,
   parameter int unsigned BOTTLE_W = BOTTLE_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   bottling_controller_if.slave  bus
);

   state_t              state_q, state_d;
   logic [PILL_W-1:0]   pill_q, pill_d, tgt_q, tgt_d, pill_inc;
   logic [BOTTLE_W-1:0] bottle_q, bottle_d;
   logic                pend_q, pend_d, pend_nx;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                busy_q, swap_q;
   logic                drop_inc, drop_clr;

   assign pill_inc = pill_q + PILL_W'(1);
   assign pend_nx  = pend_q | bus.pill_pulse;

   // Next state; commands resolved in the order stop, pause, start, pill/bottle_ready.
   always_comb begin
      state_d  = state_q;
      pill_d   = pill_q;
      tgt_d    = tgt_q;
      bottle_d = bottle_q;
      pend_d   = pend_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      drop_inc = 1'b0;
      drop_clr = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.stop || bus.pause) begin
               state_d = IDLE;
            end else if (bus.start) begin
               if (bus.target != '0) begin
                  tgt_d   = bus.target;
                  pill_d  = '0;
                  state_d = RUN;
               end else begin
                  err_d = 1'b1;
               end
            end else if (bus.clear) begin
               pill_d   = '0;
               bottle_d = '0;
               drop_clr = 1'b1;
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_d = IDLE;
               pend_d  = 1'b0;
            end else if (bus.pause) begin
               state_d = PAUSED;
            end else if (bus.pill_pulse) begin
               pill_d = pill_inc;
               if (pill_inc == tgt_q) begin
                  bottle_d = bottle_q + BOTTLE_W'(1);
                  done_d   = 1'b1;
                  state_d  = SWAP;
               end
            end
         end
         PAUSED: begin
            if (bus.stop) begin
               state_d = IDLE;
               pend_d  = 1'b0;
            end else if (bus.pause) begin
               state_d = RUN;
            end else if (bus.pill_pulse) begin
               drop_inc = 1'b1;
            end
         end
         SWAP: begin
            if (bus.stop) begin
               state_d = IDLE;
               pend_d  = 1'b0;
            end else begin
               drop_inc = bus.pill_pulse & pend_q;
               pend_d   = pend_nx;
               if (bus.bottle_ready) begin
                  pill_d = PILL_W'(pend_nx);
                  pend_d = 1'b0;
                  // A single-pill target is already full with the held pill.
                  if (pend_nx && (tgt_q == PILL_W'(1))) begin
                     bottle_d = bottle_q + BOTTLE_W'(1);
                     done_d   = 1'b1;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         pill_q   <= '0;
         tgt_q    <= '0;
         bottle_q <= '0;
         pend_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         swap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pill_q   <= pill_d;
         tgt_q    <= tgt_d;
         bottle_q <= bottle_d;
         pend_q   <= pend_d;
         done_q   <= done_d;
         err_q    <= err_d;
         busy_q   <= (state_d != IDLE);
         swap_q   <= (state_d == SWAP);
      end
   end

   assign bus.pill_count   = pill_q;
   assign bus.bottle_count = bottle_q;
   assign bus.bottle_done  = done_q;
   assign bus.swap_req     = swap_q;
   assign bus.busy         = busy_q;
   assign bus.start_err    = err_q;

`ifdef BOTTLING_DROP_COUNT_EN
   bottling_sat_counter #(.W(DROP_W)) u_drop_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (drop_clr),
      .inc   (drop_inc),
      .count (bus.drop_count)
   );
`else
   logic unused_drop;
   assign unused_drop = drop_inc ^ drop_clr;
`endif

endmodule

// File: tb/tb_bottling_controller.sv
// Directed self-checking bench for bottling_controller (drop_count checks
// follow BOTTLING_DROP_COUNT_EN).
module tb_bottling_controller;
   import bottling_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   bottling_controller_if #(.PILL_W(PILL_W_DEF), .BOTTLE_W(BOTTLE_W_DEF)) bus ();

   bottling_controller #(.PILL_W(PILL_W_DEF), .BOTTLE_W(BOTTLE_W_DEF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // One clock; pulses are dropped again after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      bus.pill_pulse   = 1'b0;
      bus.start        = 1'b0;
      bus.pause        = 1'b0;
      bus.stop         = 1'b0;
      bus.clear        = 1'b0;
      bus.bottle_ready = 1'b0;
   endtask

   task automatic chk_drop(input string tag, input int exp);
`ifdef BOTTLING_DROP_COUNT_EN
      chk(tag, 32'(bus.drop_count), 32'(exp));
`endif
   endtask

   initial begin
      reset            = 1'b1;
      bus.pill_pulse   = 1'b0;
      bus.start        = 1'b0;
      bus.pause        = 1'b0;
      bus.stop         = 1'b0;
      bus.clear        = 1'b0;
      bus.bottle_ready = 1'b0;
      bus.target       = '0;
      tick();
      tick();
      chk("rst_pill",   32'(bus.pill_count),   32'd0);
      chk("rst_bottle", 32'(bus.bottle_count), 32'd0);
      chk("rst_done",   32'(bus.bottle_done),  32'd0);
      chk("rst_swap",   32'(bus.swap_req),     32'd0);
      chk("rst_busy",   32'(bus.busy),         32'd0);
      chk("rst_err",    32'(bus.start_err),    32'd0);
      chk_drop("rst_drop", 0);
      reset = 1'b0;
      tick();

      // Fill a 3-pill bottle
      bus.target = 6'd3; bus.start = 1'b1; tick();
      chk("start_busy", 32'(bus.busy), 32'd1);
      chk("start_pill", 32'(bus.pill_count), 32'd0);
      bus.pill_pulse = 1'b1; tick();
      chk("fill_p1", 32'(bus.pill_count), 32'd1);
      chk("fill_d1", 32'(bus.bottle_done), 32'd0);
      bus.pill_pulse = 1'b1; tick();
      chk("fill_p2", 32'(bus.pill_count), 32'd2);
      bus.pill_pulse = 1'b1; tick();
      chk("fill_p3",   32'(bus.pill_count),   32'd3);
      chk("fill_done", 32'(bus.bottle_done),  32'd1);
      chk("fill_btl",  32'(bus.bottle_count), 32'd1);
      chk("fill_swap", 32'(bus.swap_req),     32'd1);
      tick();
      chk("done_pulse", 32'(bus.bottle_done), 32'd0);
      chk("swap_hold",  32'(bus.swap_req),    32'd1);

      // Two pills during swap: one held, one dropped
      bus.pill_pulse = 1'b1; tick();
      bus.pill_pulse = 1'b1; tick();
      chk_drop("swap_drop", 1);
      bus.bottle_ready = 1'b1; tick();
      chk("swap_pill", 32'(bus.pill_count), 32'd1);
      chk("swap_run",  32'(bus.swap_req),   32'd0);
      chk("swap_busy", 32'(bus.busy),       32'd1);
      chk_drop("swap_drop2", 1);
      bus.stop = 1'b1; tick();
      chk("stop_busy", 32'(bus.busy), 32'd0);
      chk("stop_pill", 32'(bus.pill_count), 32'd1);
      chk("stop_btl",  32'(bus.bottle_count), 32'd1);

      // Target 1: held pill completes the next bottle immediately
      bus.target = 6'd1; bus.start = 1'b1; tick();
      bus.pill_pulse = 1'b1; tick();
      chk("t1_done", 32'(bus.bottle_done),  32'd1);
      chk("t1_btl",  32'(bus.bottle_count), 32'd2);
      bus.pill_pulse = 1'b1; tick();
      bus.bottle_ready = 1'b1; tick();
      chk("t1_done2", 32'(bus.bottle_done),  32'd1);
      chk("t1_btl2",  32'(bus.bottle_count), 32'd3);
      chk("t1_swap",  32'(bus.swap_req),     32'd1);
      chk("t1_pill",  32'(bus.pill_count),   32'd1);
      bus.bottle_ready = 1'b1; tick();
      chk("t1_run",   32'(bus.swap_req),     32'd0);
      chk("t1_pill0", 32'(bus.pill_count),   32'd0);
      chk("t1_done3", 32'(bus.bottle_done),  32'd0);
      bus.stop = 1'b1; tick();

      // Zero target rejected
      bus.target = 6'd0; bus.start = 1'b1; tick();
      chk("err_pulse", 32'(bus.start_err), 32'd1);
      chk("err_busy",  32'(bus.busy),      32'd0);
      tick();
      chk("err_clear", 32'(bus.start_err), 32'd0);

      // Clear, then pills in IDLE ignored
      bus.clear = 1'b1; tick();
      chk("clr_pill", 32'(bus.pill_count),   32'd0);
      chk("clr_btl",  32'(bus.bottle_count), 32'd0);
      chk_drop("clr_drop", 0);
      bus.pill_pulse = 1'b1; tick();
      chk("idle_pill", 32'(bus.pill_count), 32'd0);
      chk_drop("idle_drop", 0);

      // Pause drops pills
      bus.target = 6'd5; bus.start = 1'b1; tick();
      bus.target = 6'd2;
      bus.pill_pulse = 1'b1; tick();
      bus.pause = 1'b1; tick();
      for (int i = 0; i < 4; i++) begin
         bus.pill_pulse = 1'b1; tick();
      end
      chk("pause_pill", 32'(bus.pill_count), 32'd1);
      bus.pause = 1'b1; tick();
      bus.pill_pulse = 1'b1; tick();
      chk("resume_pill", 32'(bus.pill_count), 32'd2);
      chk("resume_swap", 32'(bus.swap_req),   32'd0);
      chk_drop("pause_drop", 4);
      bus.stop = 1'b1; tick();

      // Bottle counter wrap
      bus.clear = 1'b1; tick();
      bus.target = 6'd1; bus.start = 1'b1; tick();
      for (int i = 0; i < 1023; i++) begin
         bus.pill_pulse = 1'b1; tick();
         bus.bottle_ready = 1'b1; tick();
      end
      chk("wrap_max", 32'(bus.bottle_count), 32'd1023);
      bus.pill_pulse = 1'b1; tick();
      chk("wrap_zero", 32'(bus.bottle_count), 32'd0);
      chk("wrap_done", 32'(bus.bottle_done),  32'd1);
      bus.stop = 1'b1; tick();

      // stop beats a same-cycle pill
      bus.target = 6'd3; bus.start = 1'b1; tick();
      bus.pill_pulse = 1'b1; tick();
      bus.stop = 1'b1; bus.pill_pulse = 1'b1; tick();
      chk("stop_pill_busy", 32'(bus.busy),        32'd0);
      chk("stop_pill_cnt",  32'(bus.pill_count),  32'd1);
      chk("stop_pill_done", 32'(bus.bottle_done), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
